// File: rtl/hilo_muldiv_unit.sv
// Iterative Hi/Lo multiply/divide engine with MTHI/MTLO writes and a status register.
// Optional build macro MULDIV_EARLY_TERM_EN lets multiplies leave CALC once the multiplier is exhausted.
module hilo_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] SR
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DIV0
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   rs_q, rt_q, opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_lo, neg_hi, ovf_q;
    logic               sr_div0, sr_ovf, sr_sticky;
`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0]   mplier;
`endif

    logic               is_div, is_signed, accept, rs_neg, rt_neg, calc_last;
    logic [WIDTH-1:0]   abs_rs, abs_rt;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, fix_acc, fix_prod;
    logic [WIDTH-1:0]   fix_q, fix_r;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    // A start coinciding with the done pulse is dropped, not queued.
    assign accept    = (state == S_IDLE) && start && !done;
    assign busy      = (state != S_IDLE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rs_neg = is_signed & rs_q[WIDTH-1];
        rt_neg = is_signed & rt_q[WIDTH-1];
        abs_rs = rs_neg ? -rs_q : rs_q;
        abs_rt = rt_neg ? -rt_q : rt_q;

        // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: partial remainder in the upper half, quotient shifts into the lower half.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

        calc_last = (cnt == CW'(1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div && ((mplier >> 1) == '0)) calc_last = 1'b1;
        fix_acc = acc >> cnt;
`else
        fix_acc = acc;
`endif
        fix_prod = neg_lo ? -fix_acc : fix_acc;
        fix_q    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_r    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            S_PREP: state_nxt = (is_div && rt_q == '0) ? S_DIV0 : S_CALC;
            S_CALC: if (calc_last) state_nxt = S_FIX;
            S_FIX,
            S_DIV0: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            sr_div0   <= 1'b0;
            sr_ovf    <= 1'b0;
            sr_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sr_div0   <= 1'b0;
                        sr_ovf    <= 1'b0;
                        sr_sticky <= 1'b0;
                    end else if (!start) begin
                        if (hi_we) Hi <= wdata;
                        if (lo_we) Lo <= wdata;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        Hi <= fix_r;
                        Lo <= fix_q;
                    end else begin
                        Hi <= fix_prod[2*WIDTH-1:WIDTH];
                        Lo <= fix_prod[WIDTH-1:0];
                    end
                    sr_ovf    <= ovf_q;
                    sr_sticky <= 1'b1;
                    done      <= 1'b1;
                end
                S_DIV0: begin
                    Hi        <= rs_q;
                    Lo        <= '1;
                    sr_div0   <= 1'b1;
                    sr_sticky <= 1'b1;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never exposes them before they are loaded.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_q <= op;
                    rs_q <= rs_val;
                    rt_q <= rt_val;
                end
            end
            S_PREP: begin
                neg_lo <= rs_neg ^ rt_neg;
                neg_hi <= rs_neg;
                ovf_q  <= is_div && is_signed && (rs_q == MOST_NEG) && (rt_q == '1);
                cnt    <= CW'(WIDTH);
                if (is_div) begin
                    acc  <= {{WIDTH{1'b0}}, abs_rs};
                    opnd <= abs_rt;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, abs_rt};
                    opnd <= abs_rs;
                end
`ifdef MULDIV_EARLY_TERM_EN
                mplier <= abs_rt;
`endif
            end
            S_CALC: begin
                acc <= is_div ? div_next : mul_next;
                cnt <= cnt - CW'(1);
`ifdef MULDIV_EARLY_TERM_EN
                mplier <= mplier >> 1;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        SR          = '0;
        SR[WIDTH-1] = sr_div0;
        SR[WIDTH-2] = sr_ovf;
        SR[1]       = sr_sticky;
        SR[0]       = busy;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=16): results, status bits, handshake and reset abort.
module tb_hilo_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [15:0] rs_val, rt_val, wdata;
    logic        busy, done;
    logic [15:0] Hi, Lo, SR;

    int checks   = 0;
    int failures = 0;
    int lat;
    int pulses;

    hilo_muldiv_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .Hi(Hi), .Lo(Lo), .SR(SR)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done is seen; n0 is the edge count already elapsed.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          output int n);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("sr_while_busy", {16'd0, SR}, 32'h0001);
        wait_done(0, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = OP_MULTU; rs_val = '0; rt_val = '0; wdata = '0;
        step(); step();
        // Reset dominates start and MTHI/MTLO
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 16'hAAAA;
        step();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", {16'd0, Hi}, 32'd0);
        check("rst_lo", {16'd0, Lo}, 32'd0);
        check("rst_sr", {16'd0, SR}, 32'd0);
        rst = 1'b0;
        step();

        // MULTU 0xFFFF * 0xFFFF = 0xFFFE0001
        run_op(OP_MULTU, 16'hFFFF, 16'hFFFF, lat);
`ifndef MULDIV_EARLY_TERM_EN
        check("multu_latency", lat, 32'd18);
`endif
        check("multu_hi", {16'd0, Hi}, 32'hFFFE);
        check("multu_lo", {16'd0, Lo}, 32'h0001);
        check("multu_sr", {16'd0, SR}, 32'h0002);
        check("multu_busy_at_done", {31'd0, busy}, 32'd0);
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // MULT -3 * 7 = -21
        run_op(OP_MULT, 16'hFFFD, 16'h0007, lat);
        check("mult_hi", {16'd0, Hi}, 32'hFFFF);
        check("mult_lo", {16'd0, Lo}, 32'hFFEB);
        step();

        // DIV -7 / 2 = -3 rem -1
        run_op(OP_DIV, 16'hFFF9, 16'h0002, lat);
`ifndef MULDIV_EARLY_TERM_EN
        check("div_latency", lat, 32'd18);
`endif
        check("div_lo", {16'd0, Lo}, 32'hFFFD);
        check("div_hi", {16'd0, Hi}, 32'hFFFF);
        check("div_sr", {16'd0, SR}, 32'h0002);
        step();

        // DIVU 100 / 7 = 14 rem 2
        run_op(OP_DIVU, 16'd100, 16'd7, lat);
        check("divu_lo", {16'd0, Lo}, 32'd14);
        check("divu_hi", {16'd0, Hi}, 32'd2);
        step();

        // Signed overflow: most-negative / -1
        run_op(OP_DIV, 16'h8000, 16'hFFFF, lat);
        check("ovf_lo", {16'd0, Lo}, 32'h8000);
        check("ovf_hi", {16'd0, Hi}, 32'h0000);
        check("ovf_sr", {16'd0, SR}, 32'h4002);
        step();

        // Divide by zero: short path, dividend returned in Hi
        run_op(OP_DIVU, 16'h1234, 16'h0000, lat);
`ifndef MULDIV_EARLY_TERM_EN
        check("div0_latency", lat, 32'd2);
`endif
        check("div0_hi", {16'd0, Hi}, 32'h1234);
        check("div0_lo", {16'd0, Lo}, 32'hFFFF);
        check("div0_sr", {16'd0, SR}, 32'h8002);
        step();

        // MULTU 3 * 0x8001 with start+lo_we injected at cycle 5 (both ignored)
        op = OP_MULTU; rs_val = 16'h0003; rt_val = 16'h8001; start = 1'b1;
        step();
        start = 1'b0;
        check("err_bits_cleared", {16'd0, SR}, 32'h0001);
        for (int i = 0; i < 5; i++) step();
        op = OP_DIVU; rs_val = 16'h0055; rt_val = 16'h0003; start = 1'b1;
        lo_we = 1'b1; wdata = 16'h1111;
        step();
        start = 1'b0; lo_we = 1'b0;
        check("busy_ignore_lo", {16'd0, Lo}, 32'hFFFF);
        check("busy_ignore_busy", {31'd0, busy}, 32'd1);
        wait_done(6, lat);
`ifndef MULDIV_EARLY_TERM_EN
        check("ignore_latency", lat, 32'd18);
`endif
        check("ignore_hi", {16'd0, Hi}, 32'h0001);
        check("ignore_lo", {16'd0, Lo}, 32'h8003);
        // Start during the done cycle is dropped
        op = OP_MULTU; rs_val = 16'h0007; rt_val = 16'h0007; start = 1'b1;
        step();
        start = 1'b0;
        check("start_at_done_busy", {31'd0, busy}, 32'd0);
        check("start_at_done_lo", {16'd0, Lo}, 32'h8003);
        check("start_at_done_sr", {16'd0, SR}, 32'h0002);

        // MTLO / MTHI in IDLE
        lo_we = 1'b1; wdata = 16'hBEEF;
        step();
        lo_we = 1'b0;
        check("mtlo_lo", {16'd0, Lo}, 32'hBEEF);
        check("mtlo_hi", {16'd0, Hi}, 32'h0001);
        hi_we = 1'b1; wdata = 16'hCAFE;
        step();
        hi_we = 1'b0;
        check("mthi_hi", {16'd0, Hi}, 32'hCAFE);

        // start and hi_we together: start wins, Hi untouched
        op = OP_MULTU; rs_val = 16'h0002; rt_val = 16'h0003; start = 1'b1;
        hi_we = 1'b1; wdata = 16'hDEAD;
        step();
        start = 1'b0; hi_we = 1'b0;
        check("start_wins_busy", {31'd0, busy}, 32'd1);
        check("start_wins_hi", {16'd0, Hi}, 32'hCAFE);
        wait_done(0, lat);
        check("start_wins_res_hi", {16'd0, Hi}, 32'h0000);
        check("start_wins_res_lo", {16'd0, Lo}, 32'h0006);
        step();

        // Reset at CALC cycle 8 aborts the operation
        op = OP_MULTU; rs_val = 16'hFFFF; rt_val = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", {16'd0, Hi}, 32'd0);
        check("abort_lo", {16'd0, Lo}, 32'd0);
        check("abort_sr", {16'd0, SR}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);

        // Normal operation after abort: 0x0100 * 0x0100 = 0x00010000
        run_op(OP_MULTU, 16'h0100, 16'h0100, lat);
`ifndef MULDIV_EARLY_TERM_EN
        check("post_abort_latency", lat, 32'd18);
`endif
        check("post_abort_hi", {16'd0, Hi}, 32'h0001);
        check("post_abort_lo", {16'd0, Lo}, 32'h0000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
